// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline: ALU op codes,
// forward-select codes and the ID/EX control bundle.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_ANDN = 3'b100,
    ALU_ORN  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_op;
    logic       valid;
  } ctl_t;

endpackage

// File: rtl/mips_fwd_mux.sv
// Operand forwarding mux: picks the newest in-flight
// value for one source register, Memory before Writeback.
module mips_fwd_mux
  import mips_pkg::*;
#(
  parameter int W = 32,
  parameter int R = 5
) (
  input  logic [R-1:0] src_i,
  input  logic [R-1:0] wreg_m_i,
  input  logic         we_m_i,
  input  logic [R-1:0] wreg_w_i,
  input  logic         we_w_i,
  input  logic [W-1:0] rd_i,
  input  logic [W-1:0] alu_m_i,
  input  logic [W-1:0] res_w_i,
  output fwd_sel_e     sel_o,
  output logic [W-1:0] data_o
);

  logic nz;
  logic hit_m;
  logic hit_w;

  // $0 is hardwired, so a write to it must never be forwarded
  assign nz    = (src_i != '0);
  assign hit_m = we_m_i & nz & (wreg_m_i == src_i);
  assign hit_w = we_w_i & nz & (wreg_w_i == src_i);

  always_comb begin
    sel_o  = FWD_NONE;
    data_o = rd_i;
    if (hit_m) begin
      sel_o  = FWD_M;
      data_o = alu_m_i;
    end else if (hit_w) begin
      sel_o  = FWD_W;
      data_o = res_w_i;
    end
  end

endmodule

// File: rtl/mips_id_ex_stage.sv
// ID/EX register with load-use stall detection and
// M/W forwarding into the execute-stage ALU operands.
module mips_id_ex_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] SignImmD,
  input  logic [RADDR-1:0] RsD,
  input  logic [RADDR-1:0] RtD,
  input  logic [RADDR-1:0] RdD,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic             ALUSrcD,
  input  logic             RegDstD,
  input  logic [2:0]       ALUControlD,
  input  logic             ValidD,
  input  logic             FlushE,
  input  logic [RADDR-1:0] WriteRegM,
  input  logic [RADDR-1:0] WriteRegW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic [WIDTH-1:0] ResultW,
  output logic             StallD,
  output logic [WIDTH-1:0] SrcAE,
  output logic [WIDTH-1:0] SrcBE,
  output logic [2:0]       ALUControlE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic [RADDR-1:0] WriteRegE,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MemWriteE,
  output logic             ValidE
);

  ctl_t             ctl_d;
  ctl_t             ctl_q;
  logic [WIDTH-1:0] rd1_q;
  logic [WIDTH-1:0] rd2_q;
  logic [WIDTH-1:0] imm_q;
  logic [RADDR-1:0] rs_q;
  logic [RADDR-1:0] rt_q;
  logic [RADDR-1:0] rd_q;
  logic             bubble;
  fwd_sel_e         sel_a;
  fwd_sel_e         sel_b;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic             unused_sel;

  assign StallD = ctl_q.mem_to_reg & ctl_q.valid
                & (rt_q != '0)
                & ((rt_q == RsD) | (rt_q == RtD));

  assign bubble = FlushE | StallD;

  always_comb begin
    ctl_d = '{
      reg_write:  RegWriteD,
      mem_to_reg: MemtoRegD,
      mem_write:  MemWriteD,
      alu_src:    ALUSrcD,
      reg_dst:    RegDstD,
      alu_op:     ALUControlD,
      valid:      ValidD
    };
    // bubble kills only the side-effecting bits; the rest holds
    if (bubble) begin
      ctl_d            = ctl_q;
      ctl_d.reg_write  = 1'b0;
      ctl_d.mem_to_reg = 1'b0;
      ctl_d.mem_write  = 1'b0;
      ctl_d.valid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_q <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
      imm_q <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      rd_q  <= '0;
    end else begin
      ctl_q <= ctl_d;
      if (!bubble) begin
        rd1_q <= RD1D;
        rd2_q <= RD2D;
        imm_q <= SignImmD;
        rs_q  <= RsD;
        rt_q  <= RtD;
        rd_q  <= RdD;
      end
    end
  end

  mips_fwd_mux #(.W(WIDTH), .R(RADDR)) u_fwd_a (
    .src_i    (rs_q),
    .wreg_m_i (WriteRegM),
    .we_m_i   (RegWriteM),
    .wreg_w_i (WriteRegW),
    .we_w_i   (RegWriteW),
    .rd_i     (rd1_q),
    .alu_m_i  (ALUOutM),
    .res_w_i  (ResultW),
    .sel_o    (sel_a),
    .data_o   (fwd_a)
  );

  mips_fwd_mux #(.W(WIDTH), .R(RADDR)) u_fwd_b (
    .src_i    (rt_q),
    .wreg_m_i (WriteRegM),
    .we_m_i   (RegWriteM),
    .wreg_w_i (WriteRegW),
    .we_w_i   (RegWriteW),
    .rd_i     (rd2_q),
    .alu_m_i  (ALUOutM),
    .res_w_i  (ResultW),
    .sel_o    (sel_b),
    .data_o   (fwd_b)
  );

  assign unused_sel  = ^{sel_a, sel_b};

  assign SrcAE       = fwd_a;
  assign WriteDataE  = fwd_b;
  assign SrcBE       = ctl_q.alu_src ? imm_q : fwd_b;
  assign ALUControlE = ctl_q.alu_op;
  assign WriteRegE   = ctl_q.reg_dst ? rd_q : rt_q;
  assign RegWriteE   = ctl_q.reg_write;
  assign MemtoRegE   = ctl_q.mem_to_reg;
  assign MemWriteE   = ctl_q.mem_write;
  assign ValidE      = ctl_q.valid;

endmodule

// File: tb/tb_mips_id_ex_stage.sv
// Bench for mips_id_ex_stage: directed hazard cases plus
// random traffic against an instruction-level model.
module tb_mips_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] RD1D, RD2D, SignImmD;
  logic [4:0]  RsD, RtD, RdD;
  logic        RegWriteD, MemtoRegD, MemWriteD;
  logic        ALUSrcD, RegDstD, ValidD, FlushE;
  logic [2:0]  ALUControlD;
  logic [4:0]  WriteRegM, WriteRegW;
  logic        RegWriteM, RegWriteW;
  logic [31:0] ALUOutM, ResultW;
  logic        StallD;
  logic [31:0] SrcAE, SrcBE, WriteDataE;
  logic [2:0]  ALUControlE;
  logic [4:0]  WriteRegE;
  logic        RegWriteE, MemtoRegE, MemWriteE, ValidE;

  mips_id_ex_stage dut (
    .clk(clk), .reset(reset),
    .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
    .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
    .RegDstD(RegDstD), .ALUControlD(ALUControlD),
    .ValidD(ValidD), .FlushE(FlushE),
    .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ALUOutM(ALUOutM), .ResultW(ResultW),
    .StallD(StallD), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .ALUControlE(ALUControlE), .WriteDataE(WriteDataE),
    .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ValidE(ValidE)
  );

  always #5 clk = ~clk;

  // the instruction the model believes is sitting in Execute
  typedef struct packed {
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        rw, m2r, mw, asrc, rdst, v;
    logic [2:0]  ctl;
  } e_t;

  e_t me;
  int n_cmp = 0;
  int n_bad = 0;
  bit run = 0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] r,
                                      input logic [31:0] rv);
    if (r != 0 && RegWriteM && WriteRegM == r) return ALUOutM;
    if (r != 0 && RegWriteW && WriteRegW == r) return ResultW;
    return rv;
  endfunction

  function automatic logic m_stall();
    return me.m2r && me.v && me.rt != 0 &&
           (me.rt == RsD || me.rt == RtD);
  endfunction

  task automatic check_all();
    logic [31:0] wd;
    wd = fwd(me.rt, me.rd2);
    cmp("StallD", 32'(StallD), 32'(m_stall()));
    cmp("SrcAE", SrcAE, fwd(me.rs, me.rd1));
    cmp("WriteDataE", WriteDataE, wd);
    cmp("SrcBE", SrcBE, me.asrc ? me.imm : wd);
    cmp("ALUControlE", 32'(ALUControlE), 32'(me.ctl));
    cmp("WriteRegE", 32'(WriteRegE), 32'(me.rdst ? me.rd : me.rt));
    cmp("RegWriteE", 32'(RegWriteE), 32'(me.rw));
    cmp("MemtoRegE", 32'(MemtoRegE), 32'(me.m2r));
    cmp("MemWriteE", 32'(MemWriteE), 32'(me.mw));
    cmp("ValidE", 32'(ValidE), 32'(me.v));
  endtask

  always @(negedge clk) if (run) check_all();

  task automatic model_step();
    if (reset) me = '0;
    else if (FlushE || m_stall()) begin
      me.rw = 0; me.m2r = 0; me.mw = 0; me.v = 0;
    end else begin
      me.rd1 = RD1D; me.rd2 = RD2D; me.imm = SignImmD;
      me.rs = RsD; me.rt = RtD; me.rd = RdD;
      me.rw = RegWriteD; me.m2r = MemtoRegD;
      me.mw = MemWriteD; me.asrc = ALUSrcD;
      me.rdst = RegDstD; me.v = ValidD; me.ctl = ALUControlD;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clr();
    RD1D = 0; RD2D = 0; SignImmD = 0;
    RsD = 0; RtD = 0; RdD = 0;
    RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0;
    ALUSrcD = 0; RegDstD = 0; ALUControlD = 0;
    ValidD = 0; FlushE = 0;
    WriteRegM = 0; WriteRegW = 0;
    RegWriteM = 0; RegWriteW = 0;
    ALUOutM = 0; ResultW = 0;
  endtask

  task automatic rnd();
    RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
    RsD = 5'($urandom_range(0, 3));
    RtD = 5'($urandom_range(0, 3));
    RdD = 5'($urandom_range(0, 3));
    RegWriteD = 1'($urandom); MemtoRegD = 1'($urandom);
    MemWriteD = 1'($urandom); ALUSrcD = 1'($urandom);
    RegDstD = 1'($urandom); ALUControlD = 3'($urandom);
    ValidD = ($urandom % 8) != 0;
    FlushE = ($urandom % 8) == 0;
    WriteRegM = 5'($urandom_range(0, 3));
    WriteRegW = 5'($urandom_range(0, 3));
    RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
    ALUOutM = $urandom; ResultW = $urandom;
  endtask

  task automatic lw_then_dep(input logic flush);
    clr();
    RsD = 1; RtD = 2; MemtoRegD = 1; RegWriteD = 1;
    ALUSrcD = 1; ALUControlD = 3'b010; ValidD = 1;
    tick();
    clr();
    RsD = 2; RtD = 2; RdD = 4; RegDstD = 1; RegWriteD = 1;
    ALUControlD = 3'b010; ValidD = 1; FlushE = flush;
    #2;
    cmp("lu_stall", 32'(StallD), 32'd1);
  endtask

  initial begin
    reset = 1;
    clr();
    me = '0;
    #3;
    cmp("rst_StallD", 32'(StallD), 32'd0);
    cmp("rst_SrcAE", SrcAE, 32'd0);
    cmp("rst_SrcBE", SrcBE, 32'd0);
    cmp("rst_WriteDataE", WriteDataE, 32'd0);
    cmp("rst_ALUControlE", 32'(ALUControlE), 32'd0);
    cmp("rst_ctl", 32'({RegWriteE, MemtoRegE, MemWriteE, ValidE,
                        WriteRegE}), 32'd0);
    #9;
    reset = 0;
    run = 1;

    RsD = 1; RtD = 2; RdD = 3; RegWriteD = 1; RegDstD = 1;
    ValidD = 1; ALUControlD = 3'b010; RD1D = 5; RD2D = 9;
    tick();
    cmp("pre_rst_valid", 32'(ValidE), 32'd1);
    cmp("pre_rst_rw", 32'(RegWriteE), 32'd1);
    reset = 1;
    me = '0;
    #1;
    cmp("async_rst_valid", 32'(ValidE), 32'd0);
    cmp("async_rst_rw", 32'(RegWriteE), 32'd0);
    cmp("async_rst_wreg", 32'(WriteRegE), 32'd0);
    cmp("async_rst_srca", SrcAE, 32'd0);
    tick();
    reset = 0;
    clr();

    RsD = 1; RtD = 2; RdD = 3; RegDstD = 1; RegWriteD = 1;
    ALUControlD = 3'b010; ValidD = 1;
    tick();
    RsD = 3; RtD = 5; RdD = 4; ALUControlD = 3'b110;
    tick();
    RegWriteM = 1; WriteRegM = 3; ALUOutM = 32'h7;
    #2;
    cmp("b2b_srca", SrcAE, 32'h7);
    cmp("b2b_sel", 32'(dut.sel_a), 32'd2);

    clr();
    RsD = 3; RD1D = 32'h1234; ValidD = 1; RegWriteD = 1;
    tick();
    RegWriteM = 1; WriteRegM = 3; ALUOutM = 32'hAAAA_0000;
    RegWriteW = 1; WriteRegW = 3; ResultW = 32'h5555_0000;
    #2;
    cmp("dbl_srca", SrcAE, 32'hAAAA_0000);
    clr();
    ValidD = 1; RegWriteD = 1;
    tick();
    RegWriteM = 1; WriteRegM = 0; ALUOutM = 32'hAAAA_0000;
    RegWriteW = 1; WriteRegW = 0; ResultW = 32'h5555_0000;
    #2;
    cmp("r0_srca", SrcAE, 32'h0);

    lw_then_dep(1'b0);
    tick();
    cmp("lu_bubble_valid", 32'(ValidE), 32'd0);
    cmp("lu_bubble_stall", 32'(StallD), 32'd0);
    tick();
    RegWriteW = 1; WriteRegW = 2; ResultW = 32'hCAFE_F00D;
    #1;
    cmp("lu_srca", SrcAE, 32'hCAFE_F00D);
    cmp("lu_srcb", SrcBE, 32'hCAFE_F00D);
    cmp("lu_sel", 32'(dut.sel_a), 32'd1);

    lw_then_dep(1'b1);
    tick();
    cmp("fl_bubble", 32'({RegWriteE, MemWriteE, ValidE}), 32'd0);
    FlushE = 0;
    tick();
    cmp("fl_held_valid", 32'(ValidE), 32'd1);
    cmp("fl_held_wreg", 32'(WriteRegE), 32'd4);

    clr();
    RtD = 6; ALUSrcD = 1; SignImmD = 32'hFFFF_FFFC;
    RD2D = 32'h11; ValidD = 1;
    tick();
    RegWriteM = 1; WriteRegM = 6; ALUOutM = 32'h1357;
    #2;
    cmp("imm_srcb", SrcBE, 32'hFFFF_FFFC);
    cmp("imm_wdata", WriteDataE, 32'h1357);

    repeat (3000) begin
      tick();
      if ($urandom % 200 == 0) begin
        reset = 1;
        me = '0;
        #2;
        reset = 0;
      end
      rnd();
    end

    run = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
